// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch stage with PC, next-PC selection and IF/ID register
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchAddr,
  input  logic             J,
  input  logic             JR,
  input  logic [31:0]      JrAddr,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      Instruction_id,
  output logic [31:0]      PC_plus4_id,
  output logic             Valid_id,
  output logic [CNT_W-1:0] BubbleCount
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, pc4;
  logic jmp, hold, fetch, bubble;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb state_n = RUN;
  always_comb imem_req = (state == RUN);
  assign imem_addr = pc;
  assign pc4 = pc + 32'd4;
  always_comb begin
    jmp = (J | JR) & Valid_id;
    hold = !imem_req || (Stall && !BranchTaken);
    fetch = !BranchTaken && !jmp && imem_ready;
    bubble = !hold && !fetch;
    pc_n = BranchTaken ? BranchAddr :
           jmp ? (J ? {PC_plus4_id[31:28], Instruction_id[25:0], 2'b00} : JrAddr) :
           imem_ready ? pc4 : pc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      Instruction_id <= '0;
      PC_plus4_id <= '0;
      Valid_id <= 1'b0;
      BubbleCount <= '0;
    end else if (!hold) begin
      pc <= pc_n;
      Instruction_id <= fetch ? imem_rdata : '0;
      Valid_id <= fetch;
      if (fetch) PC_plus4_id <= pc4;
      if (bubble && !(&BubbleCount)) BubbleCount <= BubbleCount + CNT_W'(1);
    end
  end
endmodule
